// File: rtl/hazard_pkg.sv
// hazard_pkg: types and constants shared by the hazard controller files.
//   state_t            : controller states (RUN, FLUSH, MEM_WAIT)
//   REG_IDX_W          : register-index width used by all source/dest ports
//   FLUSH_CYCLES_MIN/MAX: legal range of the per-branch flush length
//   legal_flush_cycles : clamps a requested flush length into that range
package hazard_pkg;

    localparam int REG_IDX_W        = 4;
    localparam int FLUSH_CYCLES_MIN = 1;
    localparam int FLUSH_CYCLES_MAX = 7;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // flush_left is 3 bits wide, so anything outside 1..7 is pulled back in.
    function automatic int legal_flush_cycles(input int fc);
        if (fc < FLUSH_CYCLES_MIN) return FLUSH_CYCLES_MIN;
        if (fc > FLUSH_CYCLES_MAX) return FLUSH_CYCLES_MAX;
        return fc;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational match of ID-stage sources against in-flight
// EXE/MEM destinations, producing the data-hazard request.
// Build option: FORWARDING_EN
//   defined   -> only load-use hazards (load in EXE feeding ID) stall
//   undefined -> any in-flight producer (EXE or MEM) of a used source stalls
// Ports:
//   id_src_1/2, id_src_1/2_used : ID instruction sources and their use flags
//   exe_dest, exe_wb_en, exe_mem_r_en : producer held in ID/EXE
//   mem_dest, mem_wb_en         : producer held in EXE/MEM
//   data_hz                     : ID instruction must stall
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_src_1,
    input  logic [REG_IDX_W-1:0] id_src_2,
    input  logic                 id_src_1_used,
    input  logic                 id_src_2_used,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    output logic                 data_hz
);

    logic m_exe1;
    logic m_exe2;
    logic m_mem1;
    logic m_mem2;

    assign m_exe1 = id_src_1_used & exe_wb_en & (id_src_1 == exe_dest);
    assign m_exe2 = id_src_2_used & exe_wb_en & (id_src_2 == exe_dest);
    assign m_mem1 = id_src_1_used & mem_wb_en & (id_src_1 == mem_dest);
    assign m_mem2 = id_src_2_used & mem_wb_en & (id_src_2 == mem_dest);

`ifdef FORWARDING_EN
    // ALU results reach ID through the forwarding unit; only a load still
    // in EXE has no value to forward yet.
    logic unused_mem_terms;
    assign unused_mem_terms = m_mem1 | m_mem2;
    assign data_hz = exe_mem_r_en & (m_exe1 | m_exe2);
`else
    logic unused_load_flag;
    assign unused_load_flag = exe_mem_r_en;
    assign data_hz = m_exe1 | m_exe2 | m_mem1 | m_mem2;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: freeze/flush control for the IF/ID and ID/EXE pipeline
// registers, plus a whole-pipe freeze while data memory is busy.
// Build option: FORWARDING_EN (selects the hazard rule inside hazard_cmp).
// Parameters:
//   FLUSH_CYCLES : flush cycles per taken branch (1..7)
//   STALL_CNT_W  : width of the saturating data-stall counter
// Ports:
//   clk, rst (async, active-low)
//   id_src_*, exe_*, mem_dest, mem_wb_en : hazard inputs
//   exe_b     : taken branch resolving in EXE
//   mem_busy  : data memory not ready
//   freeze_* / flush_* : pipeline register controls (combinational)
//   stall_cnt : data-stall cycles since reset
//
// state    | meaning
// ---------+---------------------------------------------------------
// RUN      | normal issue; data hazards stall ID
// FLUSH    | squashing wrong-path fetches, flush_left cycles remain
// MEM_WAIT | pipe frozen on mem_busy; ret_state is resumed afterwards
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_IDX_W-1:0]   id_src_1,
    input  logic [REG_IDX_W-1:0]   id_src_2,
    input  logic                   id_src_1_used,
    input  logic                   id_src_2_used,
    input  logic [REG_IDX_W-1:0]   exe_dest,
    input  logic                   exe_wb_en,
    input  logic                   exe_mem_r_en,
    input  logic                   exe_b,
    input  logic [REG_IDX_W-1:0]   mem_dest,
    input  logic                   mem_wb_en,
    input  logic                   mem_busy,
    output logic                   freeze_pc,
    output logic                   freeze_if_id,
    output logic                   flush_if_id,
    output logic                   freeze_id_exe,
    output logic                   flush_id_exe,
    output logic                   freeze_exe_mem,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int       FC_LEGAL    = legal_flush_cycles(FLUSH_CYCLES);
    localparam logic [2:0] FLUSH_LOAD = 3'(FC_LEGAL - 1);
    localparam bit       MULTI_FLUSH = (FC_LEGAL > 1);
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     ret_state;
    logic [2:0] flush_left;

    state_t state_eff;
    logic   data_hz;
    logic   flush_active;
    logic   stall;

    hazard_cmp u_cmp (
        .id_src_1      (id_src_1),
        .id_src_2      (id_src_2),
        .id_src_1_used (id_src_1_used),
        .id_src_2_used (id_src_2_used),
        .exe_dest      (exe_dest),
        .exe_wb_en     (exe_wb_en),
        .exe_mem_r_en  (exe_mem_r_en),
        .mem_dest      (mem_dest),
        .mem_wb_en     (mem_wb_en),
        .data_hz       (data_hz)
    );

    // The first non-busy cycle after MEM_WAIT already behaves as the saved
    // state, so the outputs look through MEM_WAIT to ret_state.
    always_comb begin
        state_eff    = (state == MEM_WAIT) ? ret_state : state;
        flush_active = exe_b | (state_eff == FLUSH);
        // A taken branch squashes the ID instruction, so it never stalls.
        stall        = ~exe_b & (state_eff == RUN) & data_hz;

        freeze_pc      = mem_busy | stall;
        freeze_if_id   = mem_busy | stall;
        flush_if_id    = ~mem_busy & flush_active;
        freeze_id_exe  = mem_busy;
        flush_id_exe   = ~mem_busy & (flush_active | stall);
        freeze_exe_mem = mem_busy;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            ret_state  <= RUN;
            flush_left <= 3'd0;
            stall_cnt  <= '0;
        end else if (mem_busy) begin
            // Only the first busy cycle records where to resume.
            if (state != MEM_WAIT) begin
                ret_state <= state;
                state     <= MEM_WAIT;
            end
        end else if (exe_b) begin
            if (MULTI_FLUSH) begin
                flush_left <= FLUSH_LOAD;
                state      <= FLUSH;
            end else begin
                state <= RUN;
            end
        end else if (state_eff == FLUSH) begin
            flush_left <= flush_left - 3'd1;
            state      <= (flush_left == 3'd1) ? RUN : FLUSH;
        end else begin
            state <= RUN;
            if (data_hz && (stall_cnt != {STALL_CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule
